id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage of the 5-stage LoongArch32 pipeline. Sits directly downstream of the fetch stage and upstream of execute.
- Holds the IF→ID pipeline register and decodes a fixed instruction subset.
- Reads the external register file and resolves branches. Returns br_taken/br_target to fetch.
- Stalls on RAW hazards against EX/MEM/WB; this version has no forwarding.

Parameters:
- RESET_PC, 32'h1c000000, value loaded into ds_pc on reset (cosmetic; ds_valid gates everything).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fs_to_ds_valid  in  1  fetch presents an instruction
- fs_pc  in  32  PC of the presented instruction
- fs_inst  in  32  instruction word
- ds_allowin  out  1  ID can accept fs this cycle
- es_allowin  in  1  EX can accept from ID
- ds_to_es_valid  out  1  ID output valid
- br_taken  out  1  redirect fetch
- br_target  out  32  redirect address
- rf_raddr1, rf_raddr2  out  5  regfile read addresses (combinational)
- rf_rdata1, rf_rdata2  in  32  regfile read data (combinational)
- es_valid, ms_valid, ws_valid  in  1  downstream stage valid
- es_dest, ms_dest, ws_dest  in  5  downstream destination register; 0 = none
- ds_pc  out  32  PC of the decoded instruction
- alu_op  out  4  0=ADD, 1=SUB, 2=PASS_SRC2
- alu_src1, alu_src2  out  32  operands
- dest  out  5  write-back register; 0 if no write
- mem_we  out  1  store
- res_from_mem  out  1  load
- st_data  out  32  store data

Behaviour:
- State registers: ds_valid, ds_pc, ds_inst. Reset gives ds_valid=0, ds_pc=RESET_PC, ds_inst=0.
- With ds_valid=0, the outputs ds_to_es_valid, br_taken, mem_we and res_from_mem are all 0.
- Handshake:
  - ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
  - ds_to_es_valid = ds_valid & ds_ready_go.
  - When ds_allowin=1, the next cycle gives ds_valid = fs_to_ds_valid & !br_taken. ds_pc/ds_inst load only when fs_to_ds_valid & ds_allowin.
  - When ds_allowin=0, all state holds.
- Field extraction: rd=inst[4:0], rj=inst[9:5], rk=inst[14:10].
- Decode table (match on inst bits):
  - ADD.W [31:15]=17'h00020 → rd = rj + rk.
  - SUB.W [31:15]=17'h00022 → rd = rj − rk.
  - ADDI.W [31:22]=10'h00a → rd = rj + sext(si12 [21:10]).
  - LD.W [31:22]=10'h0a2 → src1=rj, src2=sext(si12), res_from_mem=1.
  - ST.W [31:22]=10'h0a6 → mem_we=1, st_data=rd value, dest=0.
  - LU12I.W [31:25]=7'h0a → src2 = {si20 [24:5], 12'b0}, PASS_SRC2.
  - JIRL [31:26]=6'h13 → dest=rd.
  - B 6'h14.
  - BL 6'h15 → dest=1.
  - BEQ 6'h16.
  - BNE 6'h17.
- Link instructions (BL, JIRL): src1=ds_pc, src2=4, ADD.
- Undecoded instructions pass through as NOP: dest=0, mem_we=0, no branch.
- Register-file reads:
  - rf_raddr1=rj.
  - rf_raddr2 = rd for ST/BEQ/BNE, otherwise rk.
  - Reading r0 returns 0.
- Branch offsets:
  - offs16 = sext({inst[25:10], 2'b0}).
  - offs26 = sext({inst[9:0], inst[25:10], 2'b0}).
  - JIRL offset = sext({inst[25:10], 2'b0}).
- Branch targets:
  - BEQ/BNE/B/BL: ds_pc + offset.
  - JIRL: rj + offset.
- br_taken = ds_valid & ds_ready_go & (B | BL | JIRL | (BEQ & rj==rd) | (BNE & rj!=rd)). It is combinational, in the same cycle ID hands off. br_taken is never asserted while ID is stalled.
- Hazard stall:
  - A source is "used" if the instruction reads it and its index ≠ 0.
  - ds_ready_go = 0 if any used source equals es_dest (with es_valid), ms_dest (with ms_valid) or ws_dest (with ws_valid). Otherwise ds_ready_go = 1.
  - dest=0 never matches.
- Simultaneous events:
  - Branch taken with fs_to_ds_valid=1: the incoming wrong-path instruction is dropped (ds_valid←0).
  - Stall with fs_to_ds_valid=1: fetch sees ds_allowin=0 and must hold.
- Reset mid-stall: ds_valid clears the next edge. br_taken is deasserted immediately after reset.

Decomposition:
- Shared package holds:
  - opcode match constants (OP_ADD_W … OP_BNE);
  - alu_op encodings (ALU_ADD, ALU_SUB, ALU_PASS2);
  - RESET_PC.
- One natural sub-module, id_decoder: purely combinational. Maps inst to control signals (alu_op, src selects, dest select, mem flags, branch kind, reads_rk/reads_rd).
- id_stage keeps the pipeline register, handshake, hazard check and branch compare.

Test Plan:
- Reset, then fs_to_ds_valid=1, fs_pc=0x1c000000, ADDI.W r1,r0,5 (0x02801401), es_allowin=1 → the next cycle gives ds_to_es_valid=1, alu_op=ADD, src2=5, dest=1.
- BEQ r1,r2,+8 with rf_rdata1=rf_rdata2=7, ds_pc=0x1c000010 → br_taken=1, br_target=0x1c000018. The concurrent fs instruction is dropped (ds_valid=0 next cycle).
- BNE with equal operands → br_taken=0, ds_to_es_valid=1, dest=0.
- ADD.W r3,r1,r2 with es_valid=1, es_dest=2 → ds_ready_go=0, ds_allowin=0, ds_to_es_valid=0. When es_valid drops, it issues the next cycle. The same test with es_dest=0 and rk=0 does not stall.
- BL +0x100 at ds_pc=0x1c000020 → br_target=0x1c000120, dest=1, src1=0x1c000020, src2=4. JIRL r0,r1,0 with r1=0x1c000040 → br_target=0x1c000040.
- es_allowin=0 for 3 cycles with a valid instruction held → outputs stable, ds_allowin=0. Reset asserted mid-hold → ds_valid=0 and ds_to_es_valid=0 after the edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: constants and types shared by the decode stage.
//   - opcode match values for the supported LoongArch32 subset
//   - alu_op encodings
//   - decoder control bundle and selector enums
//   - RAW hazard helper
package id_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    localparam logic [16:0] OP_ADD_W   = 17'h00020;  // inst[31:15]
    localparam logic [16:0] OP_SUB_W   = 17'h00022;  // inst[31:15]
    localparam logic [9:0]  OP_ADDI_W  = 10'h00a;    // inst[31:22]
    localparam logic [9:0]  OP_LD_W    = 10'h0a2;    // inst[31:22]
    localparam logic [9:0]  OP_ST_W    = 10'h0a6;    // inst[31:22]
    localparam logic [6:0]  OP_LU12I_W = 7'h0a;      // inst[31:25]
    localparam logic [5:0]  OP_JIRL    = 6'h13;      // inst[31:26]
    localparam logic [5:0]  OP_B       = 6'h14;
    localparam logic [5:0]  OP_BL      = 6'h15;
    localparam logic [5:0]  OP_BEQ     = 6'h16;
    localparam logic [5:0]  OP_BNE     = 6'h17;

    localparam logic [3:0]  ALU_ADD   = 4'd0;
    localparam logic [3:0]  ALU_SUB   = 4'd1;
    localparam logic [3:0]  ALU_PASS2 = 4'd2;

    typedef enum logic [1:0] {SRC2_RK, SRC2_SI12, SRC2_SI20, SRC2_FOUR} src2_sel_e;
    typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_R1} dest_sel_e;
    typedef enum logic [2:0] {BR_NONE, BR_B, BR_BL, BR_JIRL, BR_BEQ, BR_BNE} br_kind_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       src1_is_pc;
        src2_sel_e  src2_sel;
        dest_sel_e  dest_sel;
        logic       mem_we;
        logic       res_from_mem;
        br_kind_e   br_kind;
        logic       reads_rj;
        logic       reads_rk;
        logic       reads_rd;
    } dec_ctrl_t;

    // A source collides with a stage when it is really read, is not r0,
    // and the stage holds a valid instruction writing that register.
    function automatic logic raw_hit(input logic [4:0] src, input logic used,
                                     input logic stage_valid, input logic [4:0] stage_dest);
        return used && (src != 5'd0) && stage_valid && (stage_dest == src);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: all non-clock signals of the decode stage.
//   slave  : the decode stage view (fetch/regfile/downstream in, decode results out)
//   master : the surrounding pipeline view (drives what the stage reads)
interface id_stage_if;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        es_valid;
    logic        ms_valid;
    logic        ws_valid;
    logic [4:0]  es_dest;
    logic [4:0]  ms_dest;
    logic [4:0]  ws_dest;
    logic [31:0] ds_pc;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  dest;
    logic        mem_we;
    logic        res_from_mem;
    logic [31:0] st_data;

    modport slave (
        input  fs_to_ds_valid, fs_pc, fs_inst, es_allowin, rf_rdata1, rf_rdata2,
               es_valid, ms_valid, ws_valid, es_dest, ms_dest, ws_dest,
        output ds_allowin, ds_to_es_valid, br_taken, br_target, rf_raddr1, rf_raddr2,
               ds_pc, alu_op, alu_src1, alu_src2, dest, mem_we, res_from_mem, st_data
    );

    modport master (
        output fs_to_ds_valid, fs_pc, fs_inst, es_allowin, rf_rdata1, rf_rdata2,
               es_valid, ms_valid, ws_valid, es_dest, ms_dest, ws_dest,
        input  ds_allowin, ds_to_es_valid, br_taken, br_target, rf_raddr1, rf_raddr2,
               ds_pc, alu_op, alu_src1, alu_src2, dest, mem_we, res_from_mem, st_data
    );
endinterface

// File: rtl/id_decoder.sv
// id_decoder: purely combinational opcode decode.
//   opcode_i : instruction bits [31:15] (all opcode fields live in this range)
//   ctrl_o   : alu op, operand/dest selects, memory flags, branch kind, source usage
// Anything not matched decodes as a NOP (no dest, no memory, no branch).
module id_decoder
    import id_stage_pkg::*;
(
    input  logic [16:0] opcode_i,
    output dec_ctrl_t   ctrl_o
);
    always_comb begin
        ctrl_o          = '0;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.src2_sel = SRC2_RK;
        ctrl_o.dest_sel = DEST_NONE;
        ctrl_o.br_kind  = BR_NONE;
        if (opcode_i == OP_ADD_W || opcode_i == OP_SUB_W) begin
            ctrl_o.alu_op   = (opcode_i == OP_SUB_W) ? ALU_SUB : ALU_ADD;
            ctrl_o.dest_sel = DEST_RD;
            ctrl_o.reads_rj = 1'b1;
            ctrl_o.reads_rk = 1'b1;
        end else if (opcode_i[16:7] == OP_ADDI_W || opcode_i[16:7] == OP_LD_W) begin
            ctrl_o.src2_sel     = SRC2_SI12;
            ctrl_o.dest_sel     = DEST_RD;
            ctrl_o.reads_rj     = 1'b1;
            ctrl_o.res_from_mem = (opcode_i[16:7] == OP_LD_W);
        end else if (opcode_i[16:7] == OP_ST_W) begin
            ctrl_o.src2_sel = SRC2_SI12;
            ctrl_o.mem_we   = 1'b1;
            ctrl_o.reads_rj = 1'b1;
            ctrl_o.reads_rd = 1'b1;
        end else if (opcode_i[16:10] == OP_LU12I_W) begin
            ctrl_o.alu_op   = ALU_PASS2;
            ctrl_o.src2_sel = SRC2_SI20;
            ctrl_o.dest_sel = DEST_RD;
        end else if (opcode_i[16:11] == OP_JIRL) begin
            ctrl_o.src1_is_pc = 1'b1;
            ctrl_o.src2_sel   = SRC2_FOUR;
            ctrl_o.dest_sel   = DEST_RD;
            ctrl_o.br_kind    = BR_JIRL;
            ctrl_o.reads_rj   = 1'b1;
        end else if (opcode_i[16:11] == OP_B) begin
            ctrl_o.br_kind = BR_B;
        end else if (opcode_i[16:11] == OP_BL) begin
            ctrl_o.src1_is_pc = 1'b1;
            ctrl_o.src2_sel   = SRC2_FOUR;
            ctrl_o.dest_sel   = DEST_R1;
            ctrl_o.br_kind    = BR_BL;
        end else if (opcode_i[16:11] == OP_BEQ || opcode_i[16:11] == OP_BNE) begin
            ctrl_o.br_kind  = (opcode_i[16:11] == OP_BEQ) ? BR_BEQ : BR_BNE;
            ctrl_o.reads_rj = 1'b1;
            ctrl_o.reads_rd = 1'b1;
        end
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage LoongArch32 pipeline.
//   clk, reset : clock, synchronous active-high reset
//   bus        : id_stage_if.slave -- fetch handshake, regfile read ports,
//                downstream valid/dest for hazards, decoded operands to EX,
//                branch redirect back to fetch
// No forwarding: any RAW hit against EX/MEM/WB holds the instruction here.
module id_stage #(
    parameter logic [31:0] RESET_PC = id_stage_pkg::RESET_PC
) (
    input  logic      clk,
    input  logic      reset,
    id_stage_if.slave bus
);
    import id_stage_pkg::*;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;

    dec_ctrl_t   ctrl;
    logic [4:0]  rd, rj, rk, raddr2;
    logic [31:0] rj_val, r2_val, si12, si20, offs16, offs26;
    logic        stall, ds_ready_go, ds_allowin, br_cond, br_taken;

    assign rd = ds_inst_q[4:0];
    assign rj = ds_inst_q[9:5];
    assign rk = ds_inst_q[14:10];

    id_decoder u_decoder (
        .opcode_i (ds_inst_q[31:15]),
        .ctrl_o   (ctrl)
    );

    assign raddr2        = ctrl.reads_rd ? rd : rk;
    assign bus.rf_raddr1 = rj;
    assign bus.rf_raddr2 = raddr2;
    assign rj_val        = (rj == 5'd0) ? 32'd0 : bus.rf_rdata1;
    assign r2_val        = (raddr2 == 5'd0) ? 32'd0 : bus.rf_rdata2;

    assign si12   = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
    assign si20   = {ds_inst_q[24:5], 12'b0};
    assign offs16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b0};
    assign offs26 = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b0};

    // Port 2 carries either rk or rd; both count as a real read.
    assign stall =
          raw_hit(rj,     ctrl.reads_rj,                 bus.es_valid, bus.es_dest)
        | raw_hit(rj,     ctrl.reads_rj,                 bus.ms_valid, bus.ms_dest)
        | raw_hit(rj,     ctrl.reads_rj,                 bus.ws_valid, bus.ws_dest)
        | raw_hit(raddr2, ctrl.reads_rk | ctrl.reads_rd, bus.es_valid, bus.es_dest)
        | raw_hit(raddr2, ctrl.reads_rk | ctrl.reads_rd, bus.ms_valid, bus.ms_dest)
        | raw_hit(raddr2, ctrl.reads_rk | ctrl.reads_rd, bus.ws_valid, bus.ws_dest);
    assign ds_ready_go = !stall;
    assign ds_allowin  = !ds_valid_q | (ds_ready_go & bus.es_allowin);

    always_comb begin
        case (ctrl.br_kind)
            BR_B, BR_BL, BR_JIRL: br_cond = 1'b1;
            BR_BEQ:               br_cond = (rj_val == r2_val);
            BR_BNE:               br_cond = (rj_val != r2_val);
            default:              br_cond = 1'b0;
        endcase
    end
    assign br_taken = ds_valid_q & ds_ready_go & br_cond;

    always_comb begin
        if (ctrl.br_kind == BR_JIRL)
            bus.br_target = rj_val + offs16;
        else if (ctrl.br_kind == BR_B || ctrl.br_kind == BR_BL)
            bus.br_target = ds_pc_q + offs26;
        else
            bus.br_target = ds_pc_q + offs16;
    end

    always_comb begin
        case (ctrl.src2_sel)
            SRC2_SI12: bus.alu_src2 = si12;
            SRC2_SI20: bus.alu_src2 = si20;
            SRC2_FOUR: bus.alu_src2 = 32'd4;
            default:   bus.alu_src2 = r2_val;
        endcase
        case (ctrl.dest_sel)
            DEST_RD: bus.dest = rd;
            DEST_R1: bus.dest = 5'd1;
            default: bus.dest = 5'd0;
        endcase
    end

    assign bus.alu_src1       = ctrl.src1_is_pc ? ds_pc_q : rj_val;
    assign bus.alu_op         = ctrl.alu_op;
    assign bus.st_data        = r2_val;
    assign bus.mem_we         = ds_valid_q & ctrl.mem_we;
    assign bus.res_from_mem   = ds_valid_q & ctrl.res_from_mem;
    assign bus.ds_pc          = ds_pc_q;
    assign bus.ds_allowin     = ds_allowin;
    assign bus.ds_to_es_valid = ds_valid_q & ds_ready_go;
    assign bus.br_taken       = br_taken;

    // A taken branch squashes whatever fetch is presenting in the same cycle.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (ds_allowin) begin
            ds_valid_d = bus.fs_to_ds_valid & !br_taken;
            if (bus.fs_to_ds_valid) begin
                ds_pc_d   = bus.fs_pc;
                ds_inst_d = bus.fs_inst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= RESET_PC;
            ds_inst_q  <= 32'd0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
    localparam logic [31:0] RST_PC  = 32'h1c00_0000;
    localparam logic [31:0] I_ADDI  = 32'h0280_1401;  // addi.w r1,r0,5

    localparam int C_NOP = 0, C_ADD = 1, C_SUB = 2, C_ADDI = 3, C_LD = 4, C_ST = 5,
                   C_LU12I = 6, C_JIRL = 7, C_B = 8, C_BL = 9, C_BEQ = 10, C_BNE = 11;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    id_stage_if bus();
    id_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    typedef struct {
        bit          ready;
        bit          taken;
        logic [31:0] target;
        bit          chk_s1;
        bit          chk_s2;
        logic [3:0]  alu;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        bit          we;
        bit          rfm;
        logic [31:0] st;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.fs_to_ds_valid = 1'b0;
        bus.fs_pc          = 32'd0;
        bus.fs_inst        = 32'd0;
        bus.es_allowin     = 1'b1;
        bus.es_valid       = 1'b0;
        bus.ms_valid       = 1'b0;
        bus.ws_valid       = 1'b0;
        bus.es_dest        = 5'd0;
        bus.ms_dest        = 5'd0;
        bus.ws_dest        = 5'd0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        bus.fs_to_ds_valid = 1'b1;
        bus.fs_pc          = pc;
        bus.fs_inst        = inst;
    endtask

    function automatic int classify(input logic [31:0] inst);
        if (inst[31:15] == 17'h00020) return C_ADD;
        if (inst[31:15] == 17'h00022) return C_SUB;
        if (inst[31:22] == 10'h00a)   return C_ADDI;
        if (inst[31:22] == 10'h0a2)   return C_LD;
        if (inst[31:22] == 10'h0a6)   return C_ST;
        if (inst[31:25] == 7'h0a)     return C_LU12I;
        if (inst[31:26] == 6'h13)     return C_JIRL;
        if (inst[31:26] == 6'h14)     return C_B;
        if (inst[31:26] == 6'h15)     return C_BL;
        if (inst[31:26] == 6'h16)     return C_BEQ;
        if (inst[31:26] == 6'h17)     return C_BNE;
        return C_NOP;
    endfunction

    function automatic logic [31:0] rv(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : regs[i];
    endfunction

    function automatic bit busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (bus.es_valid && bus.es_dest == r) || (bus.ms_valid && bus.ms_dest == r) ||
               (bus.ws_valid && bus.ws_dest == r);
    endfunction

    // Reference: architectural meaning of each instruction with two's-complement
    // immediates computed by subtracting the field weight when the sign bit is set.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [4:0]  rd, rj, rk;
        logic [31:0] imm12, o16, o26;
        rd = inst[4:0];
        rj = inst[9:5];
        rk = inst[14:10];
        imm12 = 32'(inst[21:10]) - (inst[21] ? 32'h1000 : 32'h0);
        o16   = 32'({inst[25:10], 2'b00}) - (inst[25] ? 32'h4_0000 : 32'h0);
        o26   = 32'({inst[9:0], inst[25:10], 2'b00}) - (inst[9] ? 32'h1000_0000 : 32'h0);
        e.ready = 1; e.taken = 0; e.target = 0; e.chk_s1 = 0; e.chk_s2 = 0; e.alu = 0;
        e.s1 = 0; e.s2 = 0; e.dest = 0; e.we = 0; e.rfm = 0; e.st = 0;
        case (classify(inst))
            C_ADD, C_SUB: begin
                e.ready = !busy(rj) && !busy(rk);
                e.chk_s1 = 1; e.chk_s2 = 1; e.s1 = rv(rj); e.s2 = rv(rk); e.dest = rd;
                e.alu = (classify(inst) == C_SUB) ? 4'd1 : 4'd0;
            end
            C_ADDI, C_LD: begin
                e.ready = !busy(rj);
                e.chk_s1 = 1; e.chk_s2 = 1; e.s1 = rv(rj); e.s2 = imm12; e.dest = rd;
                e.rfm = (classify(inst) == C_LD);
            end
            C_ST: begin
                e.ready = !busy(rj) && !busy(rd);
                e.we = 1; e.st = rv(rd);
            end
            C_LU12I: begin
                e.chk_s2 = 1; e.alu = 4'd2; e.s2 = {inst[24:5], 12'h000}; e.dest = rd;
            end
            C_JIRL: begin
                e.ready = !busy(rj); e.taken = 1; e.target = rv(rj) + o16;
                e.chk_s1 = 1; e.chk_s2 = 1; e.s1 = pc; e.s2 = 4; e.dest = rd;
            end
            C_B: begin
                e.taken = 1; e.target = pc + o26;
            end
            C_BL: begin
                e.taken = 1; e.target = pc + o26;
                e.chk_s1 = 1; e.chk_s2 = 1; e.s1 = pc; e.s2 = 4; e.dest = 5'd1;
            end
            C_BEQ, C_BNE: begin
                e.ready = !busy(rj) && !busy(rd);
                e.target = pc + o16;
                e.taken = (classify(inst) == C_BEQ) ? (rv(rj) == rv(rd)) : (rv(rj) != rv(rd));
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0]  rd, rj, rk;
        logic [31:0] r, inst;
        int          c;
        rd = 5'($urandom_range(0, 7));
        rj = 5'($urandom_range(0, 7));
        rk = 5'($urandom_range(0, 7));
        r  = $urandom;
        c  = $urandom_range(0, 11);
        if ((c == C_BEQ || c == C_BNE) && $urandom_range(0, 1) == 1) rd = rj;
        case (c)
            C_ADD:   inst = {17'h00020, rk, rj, rd};
            C_SUB:   inst = {17'h00022, rk, rj, rd};
            C_ADDI:  inst = {10'h00a, r[11:0], rj, rd};
            C_LD:    inst = {10'h0a2, r[11:0], rj, rd};
            C_ST:    inst = {10'h0a6, r[11:0], rj, rd};
            C_LU12I: inst = {7'h0a, r[19:0], rd};
            C_JIRL:  inst = {6'h13, r[15:0], rj, rd};
            C_B:     inst = {6'h14, r[25:0]};
            C_BL:    inst = {6'h15, r[25:0]};
            C_BEQ:   inst = {6'h16, r[15:0], rj, rd};
            C_BNE:   inst = {6'h17, r[15:0], rj, rd};
            default: begin
                inst = 32'hffff_ffff;
                for (int t = 0; t < 16; t++) begin
                    r = $urandom;
                    if (classify(r) == C_NOP) begin
                        inst = r;
                        break;
                    end
                end
            end
        endcase
        return inst;
    endfunction

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL reset_ds_to_es_valid got %b exp 0", bus.ds_to_es_valid); end
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken got %b exp 0", bus.br_taken); end
        checks++; if (bus.mem_we !== 1'b0 || bus.res_from_mem !== 1'b0) begin errors++; $display("FAIL reset_mem got we=%b rfm=%b exp 0 0", bus.mem_we, bus.res_from_mem); end
        checks++; if (bus.ds_pc !== RST_PC) begin errors++; $display("FAIL reset_ds_pc got %h exp %h", bus.ds_pc, RST_PC); end
        checks++; if (bus.ds_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", bus.ds_allowin); end
    endtask

    task automatic test_addi();
        drive_idle();
        present(32'h1c00_0000, I_ADDI);
        #1;
        checks++; if (bus.ds_allowin !== 1'b1) begin errors++; $display("FAIL addi_allowin got %b exp 1", bus.ds_allowin); end
        tick();
        drive_idle();
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", bus.ds_to_es_valid); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL addi_alu_op got %0d exp 0", bus.alu_op); end
        checks++; if (bus.alu_src2 !== 32'd5) begin errors++; $display("FAIL addi_src2 got %h exp 5", bus.alu_src2); end
        checks++; if (bus.alu_src1 !== 32'd0) begin errors++; $display("FAIL addi_src1_r0 got %h exp 0", bus.alu_src1); end
        checks++; if (bus.dest !== 5'd1) begin errors++; $display("FAIL addi_dest got %0d exp 1", bus.dest); end
        tick();
    endtask

    task automatic test_beq_drop();
        drive_idle();
        regs[1] = 32'd7;
        regs[2] = 32'd7;
        present(32'h1c00_0010, 32'h5800_0822);  // beq r1,r2,+8
        tick();
        present(32'h1c00_0014, I_ADDI);
        #1;
        checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", bus.br_taken); end
        checks++; if (bus.br_target !== 32'h1c00_0018) begin errors++; $display("FAIL beq_target got %h exp 1c000018", bus.br_target); end
        tick();
        drive_idle();
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL beq_drop got %b exp 0", bus.ds_to_es_valid); end
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL beq_drop_taken got %b exp 0", bus.br_taken); end
        tick();
    endtask

    task automatic test_bne();
        drive_idle();
        regs[1] = 32'd7;
        regs[2] = 32'd7;
        present(32'h1c00_0010, 32'h5c00_0822);  // bne r1,r2,+8
        tick();
        drive_idle();
        #1;
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got %b exp 0", bus.br_taken); end
        checks++; if (bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL bne_valid got %b exp 1", bus.ds_to_es_valid); end
        checks++; if (bus.dest !== 5'd0) begin errors++; $display("FAIL bne_dest got %0d exp 0", bus.dest); end
        tick();
    endtask

    task automatic test_hazard();
        drive_idle();
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        bus.es_valid = 1'b1;
        bus.es_dest  = 5'd2;
        present(32'h1c00_0040, 32'h0010_0823);  // add.w r3,r1,r2
        tick();
        present(32'h1c00_0044, I_ADDI);
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL haz_valid got %b exp 0", bus.ds_to_es_valid); end
        checks++; if (bus.ds_allowin !== 1'b0) begin errors++; $display("FAIL haz_allowin got %b exp 0", bus.ds_allowin); end
        tick();
        checks++; if (bus.ds_pc !== 32'h1c00_0040) begin errors++; $display("FAIL haz_hold_pc got %h exp 1c000040", bus.ds_pc); end
        bus.es_valid = 1'b0;
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b1 || bus.ds_allowin !== 1'b1) begin errors++; $display("FAIL haz_release got v=%b a=%b exp 1 1", bus.ds_to_es_valid, bus.ds_allowin); end
        checks++; if (bus.alu_src1 !== 32'h11 || bus.alu_src2 !== 32'h22 || bus.dest !== 5'd3) begin errors++; $display("FAIL haz_ops got %h %h %0d exp 11 22 3", bus.alu_src1, bus.alu_src2, bus.dest); end
        tick();
        drive_idle();
        #1;
        checks++; if (bus.ds_pc !== 32'h1c00_0044 || bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL haz_next got pc=%h v=%b exp 1c000044 1", bus.ds_pc, bus.ds_to_es_valid); end
        tick();
        present(32'h1c00_0048, 32'h0010_0023);  // add.w r3,r1,r0
        tick();
        drive_idle();
        bus.es_valid = 1'b1;
        bus.es_dest  = 5'd0;
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL haz_r0 got %b exp 1", bus.ds_to_es_valid); end
        bus.ws_valid = 1'b1;
        bus.ws_dest  = 5'd1;
        #1;
        checks++; if (bus.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL haz_ws got %b exp 0", bus.ds_to_es_valid); end
        drive_idle();
        tick();
    endtask

    task automatic test_link();
        drive_idle();
        regs[1] = 32'h1c00_0040;
        present(32'h1c00_0020, 32'h5401_0000);  // bl +0x100
        tick();
        drive_idle();
        #1;
        checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h1c00_0120) begin errors++; $display("FAIL bl_target got t=%b %h exp 1 1c000120", bus.br_taken, bus.br_target); end
        checks++; if (bus.dest !== 5'd1 || bus.alu_op !== 4'd0) begin errors++; $display("FAIL bl_dest got %0d op %0d exp 1 0", bus.dest, bus.alu_op); end
        checks++; if (bus.alu_src1 !== 32'h1c00_0020 || bus.alu_src2 !== 32'd4) begin errors++; $display("FAIL bl_ops got %h %h exp 1c000020 4", bus.alu_src1, bus.alu_src2); end
        tick();
        present(32'h1c00_0030, 32'h4c00_0020);  // jirl r0,r1,0
        tick();
        drive_idle();
        #1;
        checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h1c00_0040) begin errors++; $display("FAIL jirl_target got t=%b %h exp 1 1c000040", bus.br_taken, bus.br_target); end
        checks++; if (bus.dest !== 5'd0) begin errors++; $display("FAIL jirl_dest got %0d exp 0", bus.dest); end
        tick();
    endtask

    task automatic test_hold_reset();
        drive_idle();
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        present(32'h1c00_0050, 32'h0010_0823);
        tick();
        bus.es_allowin = 1'b0;
        present(32'h1c00_0054, I_ADDI);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.ds_allowin !== 1'b0 || bus.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL hold_hs cyc %0d got a=%b v=%b exp 0 1", c, bus.ds_allowin, bus.ds_to_es_valid); end
            checks++; if (bus.ds_pc !== 32'h1c00_0050 || bus.alu_src1 !== 32'h11) begin errors++; $display("FAIL hold_stable cyc %0d got %h %h exp 1c000050 11", c, bus.ds_pc, bus.alu_src1); end
            tick();
        end
        reset = 1'b1;
        tick();
        checks++; if (bus.ds_to_es_valid !== 1'b0 || bus.ds_pc !== RST_PC) begin errors++; $display("FAIL hold_reset got v=%b pc=%h exp 0 %h", bus.ds_to_es_valid, bus.ds_pc, RST_PC); end
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL hold_reset_br got %b exp 0", bus.br_taken); end
        reset = 1'b0;
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        logic        m_valid, fsv;
        logic [31:0] m_pc, m_inst, fpc, finst;
        exp_t        e;
        bit          taken, allow;
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        m_pc    = RST_PC;
        m_inst  = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(1, 7)] = $urandom;
            bus.fs_to_ds_valid = ($urandom_range(0, 3) != 0);
            bus.fs_pc          = $urandom & 32'hffff_fffc;
            bus.fs_inst        = gen_inst();
            bus.es_allowin     = ($urandom_range(0, 3) != 0);
            bus.es_valid       = ($urandom_range(0, 2) == 0);
            bus.ms_valid       = ($urandom_range(0, 2) == 0);
            bus.ws_valid       = ($urandom_range(0, 2) == 0);
            bus.es_dest        = 5'($urandom_range(0, 7));
            bus.ms_dest        = 5'($urandom_range(0, 7));
            bus.ws_dest        = 5'($urandom_range(0, 7));
            #1;
            e     = model(m_inst, m_pc);
            taken = m_valid && e.ready && e.taken;
            allow = !m_valid || (e.ready && bus.es_allowin);
            checks++; if (bus.ds_allowin !== allow) begin errors++; $display("FAIL rnd_allowin cyc %0d got %b exp %b", cyc, bus.ds_allowin, allow); end
            checks++; if (bus.ds_to_es_valid !== (m_valid && e.ready)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, bus.ds_to_es_valid, m_valid && e.ready); end
            checks++; if (bus.br_taken !== taken) begin errors++; $display("FAIL rnd_br_taken cyc %0d got %b exp %b", cyc, bus.br_taken, taken); end
            checks++; if (bus.mem_we !== (m_valid && e.we) || bus.res_from_mem !== (m_valid && e.rfm)) begin errors++; $display("FAIL rnd_mem cyc %0d got we=%b rfm=%b", cyc, bus.mem_we, bus.res_from_mem); end
            if (m_valid) begin
                checks++; if (bus.ds_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, bus.ds_pc, m_pc); end
                checks++; if (bus.dest !== e.dest) begin errors++; $display("FAIL rnd_dest cyc %0d inst %h got %0d exp %0d", cyc, m_inst, bus.dest, e.dest); end
                if (taken) begin
                    checks++; if (bus.br_target !== e.target) begin errors++; $display("FAIL rnd_target cyc %0d inst %h got %h exp %h", cyc, m_inst, bus.br_target, e.target); end
                end
                if (e.chk_s2) begin
                    checks++; if (bus.alu_op !== e.alu || bus.alu_src2 !== e.s2) begin errors++; $display("FAIL rnd_src2 cyc %0d inst %h got op %0d %h exp %0d %h", cyc, m_inst, bus.alu_op, bus.alu_src2, e.alu, e.s2); end
                end
                if (e.chk_s1) begin
                    checks++; if (bus.alu_src1 !== e.s1) begin errors++; $display("FAIL rnd_src1 cyc %0d inst %h got %h exp %h", cyc, m_inst, bus.alu_src1, e.s1); end
                end
                if (e.we && e.ready) begin
                    checks++; if (bus.st_data !== e.st) begin errors++; $display("FAIL rnd_st_data cyc %0d got %h exp %h", cyc, bus.st_data, e.st); end
                end
            end
            fsv   = bus.fs_to_ds_valid;
            fpc   = bus.fs_pc;
            finst = bus.fs_inst;
            tick();
            if (allow) begin
                if (fsv) begin
                    m_pc   = fpc;
                    m_inst = finst;
                end
                m_valid = fsv && !taken;
            end
        end
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_addi();
        test_beq_drop();
        test_bne();
        test_hazard();
        test_link();
        test_hold_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
